// File: rtl/rect_loop_pkg.sv
// -----------------------------------------------------------------------------
// rect_loop_pkg
// Shared definitions for the rectangle-loop (checkerboard swap) engine.
//   rl_state_t   : engine FSM states
//   CHK_A, CHK_B : the two corner patterns that identify a swappable rectangle.
//                  Corner order is {(r0,c0), (r0,c1), (r1,c0), (r1,c1)}, MSB first.
//   is_chk_pattern() : true when a 4-bit corner vector is one of the two patterns
// -----------------------------------------------------------------------------
package rect_loop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_CHECK,
        ST_SWAP,
        ST_FIN
    } rl_state_t;

    localparam logic [3:0] CHK_A = 4'b0110;
    localparam logic [3:0] CHK_B = 4'b1001;

    function automatic logic is_chk_pattern(input logic [3:0] corners);
        return (corners == CHK_A) || (corners == CHK_B);
    endfunction

endpackage

// File: rtl/rect_chk.sv
// -----------------------------------------------------------------------------
// rect_chk
// Purely combinational classifier for one random draw.
//   corners       in  : {(r0,c0),(r0,c1),(r1,c0),(r1,c1)} cell values
//   r0, r1        in  : candidate rows
//   c0, c1        in  : candidate columns
//   is_chk        out : corners form a checkerboard pattern
//   is_degenerate out : draw does not describe a proper rectangle inside the
//                       matrix (coincident rows/cols or any index out of range)
// A draw is swappable only when is_chk && !is_degenerate.
// -----------------------------------------------------------------------------
module rect_chk
    import rect_loop_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int RW   = $clog2(ROWS),
    parameter int CW   = $clog2(COLS)
) (
    input  logic [3:0]    corners,
    input  logic [RW-1:0] r0,
    input  logic [RW-1:0] r1,
    input  logic [CW-1:0] c0,
    input  logic [CW-1:0] c1,
    output logic          is_chk,
    output logic          is_degenerate
);

    always_comb begin
        // Range checks only matter when ROWS/COLS are not powers of two.
        is_degenerate = (r0 == r1) || (c0 == c1)
                     || (int'(r0) >= ROWS) || (int'(r1) >= ROWS)
                     || (int'(c0) >= COLS) || (int'(c1) >= COLS);
        is_chk        = is_chk_pattern(corners);
    end

endmodule

// File: rtl/rect_loop_engine.sv
// -----------------------------------------------------------------------------
// rect_loop_engine
// Runs ITERATIONS random swap attempts on a ROWS x COLS binary matrix. Each
// accepted draw names two rows and two columns; if the four corner cells form
// a checkerboard they are all inverted, which keeps every row and column sum.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, m_in         : begin a run with matrix m_in (cell (r,c) = bit r*COLS+c)
//   rnd_valid/rnd_ready : handshake for one draw (rnd_r0/r1, rnd_c0/c1)
//   m_out               : current matrix
//   busy, done          : run in progress / one-cycle end-of-run pulse
//   swap_count          : swaps performed in the current or last run
//   last_r0/r1/c0/c1    : indices of the most recent swap
// -----------------------------------------------------------------------------
module rect_loop_engine
    import rect_loop_pkg::*;
#(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int ITERATIONS = 8,
    localparam int RW         = $clog2(ROWS),
    localparam int CW         = $clog2(COLS),
    localparam int NW         = $clog2(ITERATIONS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] m_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [RW-1:0]        rnd_r0,
    input  logic [RW-1:0]        rnd_r1,
    input  logic [CW-1:0]        rnd_c0,
    input  logic [CW-1:0]        rnd_c1,
    output logic [ROWS*COLS-1:0] m_out,
    output logic                 busy,
    output logic                 done,
    output logic [NW-1:0]        swap_count,
    output logic [RW-1:0]        last_r0,
    output logic [RW-1:0]        last_r1,
    output logic [CW-1:0]        last_c0,
    output logic [CW-1:0]        last_c1
);

    localparam int             N      = ROWS * COLS;
    localparam logic [NW-1:0]  ITER_N = NW'(ITERATIONS);

    rl_state_t     state_reg;
    logic [N-1:0]  m_reg;
    logic [RW-1:0] draw_r0_reg, draw_r1_reg;
    logic [CW-1:0] draw_c0_reg, draw_c1_reg;
    logic [NW-1:0] attempt_reg, swap_count_reg;
    logic [RW-1:0] last_r0_reg, last_r1_reg;
    logic [CW-1:0] last_c0_reg, last_c1_reg;
    logic          busy_reg, done_reg, rnd_ready_reg;

    logic [NW-1:0] attempt_next;
    logic [N-1:0]  sel_00, sel_01, sel_10, sel_11;
    logic [N-1:0]  flip_mask;
    logic [3:0]    corners;
    logic          chk_pattern, chk_degen, chk_hit;

    // One-hot cell selectors for the four corners of the registered draw.
    // An out-of-range index matches no cell, so its corner simply reads 0
    // and the flip mask never touches cells outside the matrix.
    genvar gi;
    for (gi = 0; gi < N; gi++) begin : g_cell
        localparam logic [RW-1:0] ROW_I = RW'(gi / COLS);
        localparam logic [CW-1:0] COL_I = CW'(gi % COLS);
        assign sel_00[gi] = (draw_r0_reg == ROW_I) && (draw_c0_reg == COL_I);
        assign sel_01[gi] = (draw_r0_reg == ROW_I) && (draw_c1_reg == COL_I);
        assign sel_10[gi] = (draw_r1_reg == ROW_I) && (draw_c0_reg == COL_I);
        assign sel_11[gi] = (draw_r1_reg == ROW_I) && (draw_c1_reg == COL_I);
    end

    assign corners   = {|(m_reg & sel_00), |(m_reg & sel_01),
                        |(m_reg & sel_10), |(m_reg & sel_11)};
    assign flip_mask = sel_00 | sel_01 | sel_10 | sel_11;

    rect_chk #(
        .ROWS (ROWS),
        .COLS (COLS),
        .RW   (RW),
        .CW   (CW)
    ) u_chk (
        .corners       (corners),
        .r0            (draw_r0_reg),
        .r1            (draw_r1_reg),
        .c0            (draw_c0_reg),
        .c1            (draw_c1_reg),
        .is_chk        (chk_pattern),
        .is_degenerate (chk_degen)
    );

    assign chk_hit      = chk_pattern && !chk_degen;
    assign attempt_next = attempt_reg + 1'b1;

    // busy/done/rnd_ready are registered alongside the state so they are
    // exact functions of the state the FSM is entering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            m_reg          <= '0;
            draw_r0_reg    <= '0;
            draw_r1_reg    <= '0;
            draw_c0_reg    <= '0;
            draw_c1_reg    <= '0;
            attempt_reg    <= '0;
            swap_count_reg <= '0;
            last_r0_reg    <= '0;
            last_r1_reg    <= '0;
            last_c0_reg    <= '0;
            last_c1_reg    <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            rnd_ready_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg <= ST_LOAD;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    m_reg          <= m_in;
                    swap_count_reg <= '0;
                    attempt_reg    <= '0;
                    rnd_ready_reg  <= 1'b1;
                    state_reg      <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (rnd_valid && rnd_ready_reg) begin
                        draw_r0_reg   <= rnd_r0;
                        draw_r1_reg   <= rnd_r1;
                        draw_c0_reg   <= rnd_c0;
                        draw_c1_reg   <= rnd_c1;
                        rnd_ready_reg <= 1'b0;
                        state_reg     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    attempt_reg <= attempt_next;
                    if (chk_hit) begin
                        state_reg <= ST_SWAP;
                    end else if (attempt_next == ITER_N) begin
                        state_reg <= ST_FIN;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg     <= ST_FETCH;
                        rnd_ready_reg <= 1'b1;
                    end
                end
                ST_SWAP: begin
                    // Matrix is unchanged since CHECK, so the flip mask still
                    // names exactly the four checkerboard corners.
                    m_reg          <= m_reg ^ flip_mask;
                    swap_count_reg <= swap_count_reg + 1'b1;
                    last_r0_reg    <= draw_r0_reg;
                    last_r1_reg    <= draw_r1_reg;
                    last_c0_reg    <= draw_c0_reg;
                    last_c1_reg    <= draw_c1_reg;
                    if (attempt_reg == ITER_N) begin
                        state_reg <= ST_FIN;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg     <= ST_FETCH;
                        rnd_ready_reg <= 1'b1;
                    end
                end
                ST_FIN: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                    rnd_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign m_out      = m_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign rnd_ready  = rnd_ready_reg;
    assign swap_count = swap_count_reg;
    assign last_r0    = last_r0_reg;
    assign last_r1    = last_r1_reg;
    assign last_c0    = last_c0_reg;
    assign last_c1    = last_c1_reg;

endmodule

// File: tb/tb_rect_loop_engine.sv
// -----------------------------------------------------------------------------
// tb_rect_loop_engine
// Three engine instances sharing clk/rst_n:
//   u_a : 2x2, ITERATIONS=1  (single-swap directed run)
//   u_b : 4x4, ITERATIONS=3  (identity matrix, fixed draws)
//   u_c : 4x4, ITERATIONS=8  (random matrices/draws against a matrix model,
//                             FETCH stall, start while busy, reset mid-swap)
// -----------------------------------------------------------------------------
module tb_rect_loop_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: 2x2, ITERATIONS=1 ----------------
    logic       a_start = 1'b0, a_rnd_valid = 1'b0;
    logic [3:0] a_m_in = '0;
    logic       a_r0 = 1'b0, a_r1 = 1'b0, a_c0 = 1'b0, a_c1 = 1'b0;
    logic       a_rnd_ready, a_busy, a_done;
    logic [3:0] a_m_out;
    logic [0:0] a_swap_count;
    logic       a_lr0, a_lr1, a_lc0, a_lc1;

    rect_loop_engine #(.ROWS(2), .COLS(2), .ITERATIONS(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .m_in(a_m_in),
        .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready),
        .rnd_r0(a_r0), .rnd_r1(a_r1), .rnd_c0(a_c0), .rnd_c1(a_c1),
        .m_out(a_m_out), .busy(a_busy), .done(a_done), .swap_count(a_swap_count),
        .last_r0(a_lr0), .last_r1(a_lr1), .last_c0(a_lc0), .last_c1(a_lc1)
    );

    // ---------------- instance B: 4x4, ITERATIONS=3 ----------------
    logic        b_start = 1'b0, b_rnd_valid = 1'b0;
    logic [15:0] b_m_in = '0;
    logic [1:0]  b_r0 = '0, b_r1 = '0, b_c0 = '0, b_c1 = '0;
    logic        b_rnd_ready, b_busy, b_done;
    logic [15:0] b_m_out;
    logic [1:0]  b_swap_count;
    logic [1:0]  b_lr0, b_lr1, b_lc0, b_lc1;

    rect_loop_engine #(.ROWS(4), .COLS(4), .ITERATIONS(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .m_in(b_m_in),
        .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
        .rnd_r0(b_r0), .rnd_r1(b_r1), .rnd_c0(b_c0), .rnd_c1(b_c1),
        .m_out(b_m_out), .busy(b_busy), .done(b_done), .swap_count(b_swap_count),
        .last_r0(b_lr0), .last_r1(b_lr1), .last_c0(b_lc0), .last_c1(b_lc1)
    );

    // ---------------- instance C: 4x4, ITERATIONS=8 ----------------
    localparam int C_ITER = 8;
    logic        c_start = 1'b0, c_rnd_valid = 1'b0;
    logic [15:0] c_m_in = '0;
    logic [1:0]  c_r0 = '0, c_r1 = '0, c_c0 = '0, c_c1 = '0;
    logic        c_rnd_ready, c_busy, c_done;
    logic [15:0] c_m_out;
    logic [3:0]  c_swap_count;
    logic [1:0]  c_lr0, c_lr1, c_lc0, c_lc1;

    rect_loop_engine #(.ROWS(4), .COLS(4), .ITERATIONS(C_ITER)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .m_in(c_m_in),
        .rnd_valid(c_rnd_valid), .rnd_ready(c_rnd_ready),
        .rnd_r0(c_r0), .rnd_r1(c_r1), .rnd_c0(c_c0), .rnd_c1(c_c1),
        .m_out(c_m_out), .busy(c_busy), .done(c_done), .swap_count(c_swap_count),
        .last_r0(c_lr0), .last_r1(c_lr1), .last_c0(c_lc0), .last_c1(c_lc1)
    );

    // ---------------- reference model for instance C ----------------
    bit mm [4][4];
    int m_swaps;
    int m_last [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic model_load(input logic [15:0] v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                mm[r][c] = v[r*4+c];
        m_swaps = 0;
    endtask

    function automatic logic [15:0] model_pack();
        logic [15:0] v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[r*4+c] = mm[r][c];
        return v;
    endfunction

    // A rectangle is swappable when its diagonal cells agree, its
    // anti-diagonal cells agree, and the two diagonals differ.
    function automatic bit model_is_chk(input int r0, input int r1, input int c0, input int c1);
        if (r0 == r1 || c0 == c1) return 1'b0;
        return (mm[r0][c0] != mm[r0][c1]) && (mm[r0][c0] == mm[r1][c1])
            && (mm[r0][c1] == mm[r1][c0]);
    endfunction

    task automatic model_apply(input int r0, input int r1, input int c0, input int c1);
        if (model_is_chk(r0, r1, c0, c1)) begin
            mm[r0][c0] = !mm[r0][c0];
            mm[r0][c1] = !mm[r0][c1];
            mm[r1][c0] = !mm[r1][c0];
            mm[r1][c1] = !mm[r1][c1];
            m_swaps++;
            m_last = '{r0, r1, c0, c1};
        end
    endtask

    // Random draw; half of the time hunt for a swappable rectangle so that
    // runs contain a healthy mix of swaps and rejections.
    task automatic pick_draw(output int r0, output int r1, output int c0, output int c1);
        bit want;
        want = 1'($urandom_range(0, 1));
        r0 = $urandom_range(0, 3); r1 = $urandom_range(0, 3);
        c0 = $urandom_range(0, 3); c1 = $urandom_range(0, 3);
        if (want) begin
            for (int t = 0; t < 24; t++) begin
                int a, b, c, d;
                a = $urandom_range(0, 3); b = $urandom_range(0, 3);
                c = $urandom_range(0, 3); d = $urandom_range(0, 3);
                if (model_is_chk(a, b, c, d)) begin
                    r0 = a; r1 = b; c0 = c; c1 = d;
                    break;
                end
            end
        end
    endtask

    function automatic int row_sum(input logic [15:0] v, input int r);
        int s = 0;
        for (int c = 0; c < 4; c++) s += int'(v[r*4+c]);
        return s;
    endfunction

    function automatic int col_sum(input logic [15:0] v, input int c);
        int s = 0;
        for (int r = 0; r < 4; r++) s += int'(v[r*4+c]);
        return s;
    endfunction

    // One full run on instance C. stall_len>0 holds rnd_valid low for that
    // many cycles at the first FETCH; hold_start keeps start high and changes
    // m_in for the whole run so any reload or restart would show up.
    task automatic run_c(input logic [15:0] mat, input int stall_len, input bit hold_start);
        int busy_cnt, stalls, accepted, cyc;
        bit seen_done, stalled;
        int r0, r1, c0, c1;
        model_load(mat);
        busy_cnt = 0; stalls = 0; accepted = 0; cyc = 0;
        seen_done = 1'b0; stalled = 1'b0;
        c_start = 1'b1;
        c_m_in  = mat;
        @(negedge clk);                       // LOAD
        if (!hold_start) c_start = 1'b0;
        while (!seen_done && cyc < 400) begin
            if (c_busy) busy_cnt++;
            if (c_done) begin
                seen_done = 1'b1;
                c_start = 1'b0;
            end else begin
                if (c_rnd_ready) begin
                    if (hold_start) c_m_in = ~mat;
                    if (stall_len > 0 && !stalled) begin
                        stalled = 1'b1;
                        c_rnd_valid = 1'b0;
                        for (int i = 0; i < stall_len; i++) begin
                            @(negedge clk);
                            cyc++;
                            if (c_busy) busy_cnt++;
                            stalls++;
                            check("c_stall_ready", c_rnd_ready, 1);
                            check("c_stall_matrix", c_m_out, model_pack());
                        end
                    end
                    check("c_fetch_matrix", c_m_out, model_pack());
                    check("c_fetch_swaps", c_swap_count, m_swaps);
                    if ($urandom_range(0, 3) == 0) begin
                        c_rnd_valid = 1'b0;
                        stalls++;
                    end else begin
                        pick_draw(r0, r1, c0, c1);
                        c_r0 = 2'(r0); c_r1 = 2'(r1); c_c0 = 2'(c0); c_c1 = 2'(c1);
                        c_rnd_valid = 1'b1;
                        accepted++;
                        model_apply(r0, r1, c0, c1);
                    end
                end else begin
                    c_rnd_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        c_rnd_valid = 1'b0;
        check("c_done_seen", seen_done, 1);
        check("c_accepted", accepted, C_ITER);
        check("c_busy_cycles", busy_cnt, 2 + 2*C_ITER + m_swaps + stalls);
        check("c_final_matrix", c_m_out, model_pack());
        check("c_final_swaps", c_swap_count, m_swaps);
        check("c_last_r0", c_lr0, m_last[0]);
        check("c_last_r1", c_lr1, m_last[1]);
        check("c_last_c0", c_lc0, m_last[2]);
        check("c_last_c1", c_lc1, m_last[3]);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("c_rowsum%0d", i), row_sum(c_m_out, i), row_sum(mat, i));
            check($sformatf("c_colsum%0d", i), col_sum(c_m_out, i), col_sum(mat, i));
        end
        @(negedge clk);                       // IDLE
        check("c_done_pulse", c_done, 0);
        check("c_idle_busy", c_busy, 0);
        @(negedge clk);
        check("c_idle_hold", c_m_out, model_pack());
        $display("run_c m_in=%04h m_out=%04h swaps=%0d stalls=%0d hold_start=%0d",
                 mat, c_m_out, m_swaps, stalls, hold_start);
    endtask

    int b_dr [3][4];

    initial begin
        int busy_cnt, k, cyc;
        bit seen_done;
        m_last = '{0, 0, 0, 0};
        m_swaps = 0;

        // ---- reset state ----
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_c_m_out", c_m_out, 0);
        check("rst_c_busy", c_busy, 0);
        check("rst_c_done", c_done, 0);
        check("rst_c_ready", c_rnd_ready, 0);
        check("rst_c_swaps", c_swap_count, 0);
        check("rst_c_last", {c_lr0, c_lr1, c_lc0, c_lc1}, 0);
        check("rst_a_ready", a_rnd_ready, 0);
        check("rst_b_busy", b_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- A: 2x2 single swap, m_in=0110, draw (0,1,0,1) ----
        a_start = 1'b1; a_m_in = 4'b0110;
        @(negedge clk);                       // LOAD
        a_start = 1'b0;
        check("a_load_busy", a_busy, 1);
        check("a_load_ready", a_rnd_ready, 0);
        @(negedge clk);                       // FETCH
        check("a_fetch_ready", a_rnd_ready, 1);
        check("a_fetch_matrix", a_m_out, 4'b0110);
        a_r0 = 1'b0; a_r1 = 1'b1; a_c0 = 1'b0; a_c1 = 1'b1; a_rnd_valid = 1'b1;
        @(negedge clk);                       // CHECK
        a_rnd_valid = 1'b0;
        check("a_check_ready", a_rnd_ready, 0);
        @(negedge clk);                       // SWAP
        check("a_swap_nodone", a_done, 0);
        @(negedge clk);                       // FIN
        check("a_fin_done", a_done, 1);
        check("a_fin_matrix", a_m_out, 4'b1001);
        check("a_fin_swaps", a_swap_count, 1);
        check("a_fin_last", {a_lr0, a_lr1, a_lc0, a_lc1}, 4'b0101);
        @(negedge clk);                       // IDLE
        check("a_idle_done", a_done, 0);
        check("a_idle_busy", a_busy, 0);
        check("a_idle_hold", a_m_out, 4'b1001);
        $display("run_a m_out=%04b swaps=%0d", a_m_out, a_swap_count);

        // ---- B: 4x4 identity, ITERATIONS=3 ----
        b_dr = '{'{0, 0, 1, 1}, '{0, 1, 0, 1}, '{2, 2, 0, 3}};
        b_start = 1'b1; b_m_in = 16'h8421;
        @(negedge clk);                       // LOAD
        b_start = 1'b0;
        busy_cnt = 0; k = 0; cyc = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 100) begin
            if (b_busy) busy_cnt++;
            if (b_done) seen_done = 1'b1;
            else begin
                if (b_rnd_ready && k < 3) begin
                    b_r0 = 2'(b_dr[k][0]); b_r1 = 2'(b_dr[k][1]);
                    b_c0 = 2'(b_dr[k][2]); b_c1 = 2'(b_dr[k][3]);
                    b_rnd_valid = 1'b1;
                    k++;
                end else begin
                    b_rnd_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        b_rnd_valid = 1'b0;
        check("b_done_seen", seen_done, 1);
        check("b_draws_used", k, 3);
        check("b_busy_cycles", busy_cnt, 9);
        check("b_matrix", b_m_out, 16'h8412);
        check("b_swaps", b_swap_count, 1);
        check("b_last", {b_lr0, b_lr1, b_lc0, b_lc1}, 8'b00_01_00_01);
        $display("run_b m_out=%04h swaps=%0d busy_cycles=%0d", b_m_out, b_swap_count, busy_cnt);
        @(negedge clk);

        // ---- C: random runs, stall, start held while busy ----
        for (int n = 0; n < 4; n++) run_c(16'($urandom()), 0, 1'b0);
        run_c(16'($urandom()), 20, 1'b0);
        run_c(16'($urandom()), 0, 1'b1);

        // ---- C: reset pulsed during SWAP ----
        c_start = 1'b1; c_m_in = 16'h0012;
        @(negedge clk);                       // LOAD
        c_start = 1'b0;
        @(negedge clk);                       // FETCH
        check("c_rst_fetch_ready", c_rnd_ready, 1);
        c_r0 = 2'd0; c_r1 = 2'd1; c_c0 = 2'd0; c_c1 = 2'd1; c_rnd_valid = 1'b1;
        @(negedge clk);                       // CHECK
        c_rnd_valid = 1'b0;
        @(negedge clk);                       // SWAP
        rst_n = 1'b0;
        #1;
        check("c_rst_m_out", c_m_out, 0);
        check("c_rst_busy", c_busy, 0);
        check("c_rst_done", c_done, 0);
        check("c_rst_ready", c_rnd_ready, 0);
        check("c_rst_swaps", c_swap_count, 0);
        check("c_rst_last", {c_lr0, c_lr1, c_lc0, c_lc1}, 0);
        m_last = '{0, 0, 0, 0};
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("c_rst_no_done", c_done, 0);
            check("c_rst_idle", c_busy, 0);
        end
        $display("reset_mid_swap m_out=%04h busy=%0d", c_m_out, c_busy);
        run_c(16'($urandom()), 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_loop_engine.md
RECT_LOOP_ENGINE -- requirements
Module: rect_loop_engine

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of matrix rows, minimum 2.
REQ-002 SHALL have parameter COLS, default 4: number of matrix columns, minimum 2.
REQ-003 SHALL have parameter ITERATIONS, default 8: swap attempts per run, minimum 1.
REQ-004 SHALL have derived localparams RW = $clog2(ROWS), CW = $clog2(COLS), and NW = $clog2(ITERATIONS+1).
REQ-005 Ports:
- clk input 1: single clock, rising edge.
- rst_n input 1: asynchronous, active-low reset.
- start input 1: begin a run; sampled only in IDLE.
- m_in input ROWS*COLS: matrix to load; cell (r,c) is bit r*COLS+c.
- rnd_valid input 1: a random draw is presented.
- rnd_ready output 1: engine accepts a draw.
- rnd_r0, rnd_r1 input RW each: candidate rows.
- rnd_c0, rnd_c1 input CW each: candidate columns.
- m_out output ROWS*COLS: current internal matrix.
- busy output 1: run in progress.
- done output 1: one-cycle end-of-run pulse.
- swap_count output NW: swaps performed in the current or last run.
- last_r0, last_r1 output RW each: rows of the most recent swap.
- last_c0, last_c1 output CW each: columns of the most recent swap.

Function
REQ-006 SHALL implement the FSM states IDLE, LOAD, FETCH, CHECK, SWAP, and FIN.
REQ-007 In IDLE with start=1, SHALL go to LOAD; start in any other state SHALL be ignored.
REQ-008 LOAD SHALL copy m_in into the matrix register, clear swap_count and the attempt counter, and go to FETCH; busy SHALL be 1 from LOAD through FIN inclusive.
REQ-009 rnd_ready SHALL be 1 only in FETCH; a draw is accepted on a cycle with rnd_valid && rnd_ready; the draw is registered, and the FSM goes to CHECK.
REQ-010 If rnd_valid=0, FETCH SHALL hold indefinitely with no counter change.
REQ-011 CHECK SHALL increment the attempt counter once per draw.
REQ-012 A draw is degenerate if r0==r1, c0==c1, any row index >= ROWS, or any column index >= COLS; a degenerate draw SHALL cause no matrix change.
REQ-013 A non-degenerate draw is a checkerboard if {(r0,c0),(r0,c1),(r1,c0),(r1,c1)} equals {0,1,1,0} or {1,0,0,1}.
REQ-014 For a checkerboard, CHECK SHALL go to SWAP; otherwise it SHALL go to FETCH, or to FIN if the attempt limit is reached.
REQ-015 SWAP SHALL invert exactly those four cells in one cycle, increment swap_count, and load last_r0/r1/c0/c1 with the draw.
REQ-016 After SWAP, the FSM SHALL go to FETCH, or to FIN if the attempt counter equals ITERATIONS.
REQ-017 FIN SHALL assert done for exactly one cycle and then go to IDLE.
REQ-018 m_out, swap_count, and last_* SHALL hold their values in IDLE until the next LOAD.
REQ-019 Every row sum and every column sum of the matrix SHALL be invariant across a run.
REQ-020 Latency: a run SHALL take exactly ITERATIONS accepted draws; each attempt SHALL take 2 cycles (FETCH to CHECK), plus 1 for SWAP, plus any rnd_valid stall cycles.

Reset
REQ-021 While rst_n=0, the engine SHALL asynchronously force state IDLE, the matrix to all zero, busy=0, done=0, rnd_ready=0, swap_count=0, the attempt counter to 0, and last_* to 0.
REQ-022 Reset asserted mid-run SHALL abort the run without asserting done; after release, the engine SHALL wait in IDLE for start.

Structure
REQ-023 A shared package rect_loop_pkg SHALL hold the state enum rl_state_t and the checkerboard patterns CHK_A=4'b0110 and CHK_B=4'b1001.
REQ-024 Checkerboard detection SHALL be a combinational sub-module rect_chk with a 4-bit corner input and outputs is_chk and is_degenerate.
REQ-025 All sequential logic SHALL reside in rect_loop_engine.

Verification
REQ-026 2x2, ITERATIONS=1, m_in=0110, draw (0,1,0,1) -> m_out=1001, swap_count=1, last_* = 0,1,0,1, done pulse after the SWAP cycle.
REQ-027 4x4 identity, ITERATIONS=3, draws (0,0,c0=1,c1=1), (0,1,0,1), (2,2,0,3) -> first and third rejected, second swaps, swap_count=1, done after the 3rd attempt.
REQ-028 rnd_valid held low 20 cycles in FETCH -> no state, counter, or matrix change; rnd_ready stays 1.
REQ-029 Random 4x4 matrix, ITERATIONS=8, random draws -> row and column sums of m_out equal those of m_in at done; scoreboard matches a reference model.
REQ-030 rst_n pulsed low during SWAP -> all outputs zero immediately and no done pulse; a new start then runs normally.
REQ-031 start asserted while busy -> ignored; m_out is not reloaded and the attempt count is unaffected.
